// File: rtl/store_align.sv
// store_align: store-side lane aligner between the MEM stage and a word-wide
// data-memory write port. Accepts one byte/half/word store at a time, shifts
// data into byte lanes and generates byte enables. Boundary-crossing stores
// are issued as two beats when STORE_ALIGN_SPLIT_EN is defined, otherwise
// they are rejected with a one-cycle st_err pulse (as are illegal sizes).
module store_align #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
);

`ifdef STORE_ALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t state, state_nx;

  logic        accept, legal, split, reject, go;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  m8;
  logic [63:0] sh;
  logic        split_q;
  logic [31:0] hi_wdata;
  logic [3:0]  hi_be;

  assign st_ready  = (state == IDLE);
  assign mem_valid = (state != IDLE);
  assign accept    = st_valid && st_ready;

  // Request decode: lane mask, 64-bit shifted data/enables, split detection
  always_comb begin
    off   = st_addr[1:0];
    mask  = '0;
    legal = 1'b1;
    case (st_size)
      3'b000:  mask = 4'b1111;
      3'b001:  mask = 4'b0001;
      3'b010:  mask = 4'b0011;
      default: legal = 1'b0;
    endcase
    m8     = {4'b0000, mask} << off;
    split  = |m8[7:4];
    sh     = {32'h0, st_data} << {off, 3'b000};
    reject = !legal || (split && !SplitEn);
    go     = accept && !reject;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = BEAT0;
      BEAT0:   if (mem_ready) state_nx = (SplitEn && split_q) ? BEAT1 : IDLE;
      BEAT1:   if (mem_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Beat datapath: capture at accept, swap in the upper half after beat 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_err    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      split_q   <= 1'b0;
      hi_wdata  <= '0;
      hi_be     <= '0;
    end else begin
      st_err <= accept && reject;
      if (go) begin
        mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= sh[31:0];
        mem_be    <= m8[3:0];
        split_q   <= split;
        hi_wdata  <= sh[63:32];
        hi_be     <= m8[7:4];
      end else if (state == BEAT0 && mem_ready && SplitEn && split_q) begin
        mem_addr  <= mem_addr + ADDR_W'(4);
        mem_wdata <= hi_wdata;
        mem_be    <= hi_be;
      end
    end
  end

endmodule

// File: tb/tb_store_align.sv
// Directed self-checking bench for store_align. Inputs driven and outputs
// sampled on the falling clock edge. Split-dependent expectations follow
// STORE_ALIGN_SPLIT_EN.
module tb_store_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  int n_cmp  = 0;
  int n_fail = 0;

  store_align #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .st_err(st_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  always #5 clk = ~clk;

  // Present one request for one cycle; returns at the negedge after accept
  task automatic issue(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    st_data  = 32'hFFFF_FFFF;
    st_addr  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st_valid = 1'b0; st_size = '0; st_addr = '0; st_data = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (mem_be !== 4'b0) begin n_fail++; $display("FAIL reset_mem_be got %b want 0000", mem_be); end
    n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL reset_st_err got %b want 0", st_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready got %b want 1", st_ready); end
  endtask

  task automatic test_byte();
    mem_ready = 1'b1;
    issue(3'b001, 32'h0000_1003, 32'h0000_00A5);
    n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid got %b want 1", mem_valid); end
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL sb_st_ready got %b want 0", st_ready); end
    n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr got %h want 00001000", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hA500_0000) begin n_fail++; $display("FAIL sb_wdata got %h want a5000000", mem_wdata); end
    n_cmp++; if (mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", mem_be); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL sb_done_valid got %b want 0", mem_valid); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL sb_done_ready got %b want 1", st_ready); end
  endtask

  task automatic test_half();
    mem_ready = 1'b1;
    issue(3'b010, 32'h0000_2001, 32'h0000_BEEF);
    n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL sh_valid got %b want 1", mem_valid); end
    n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL sh_err got %b want 0", st_err); end
    n_cmp++; if (mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_addr got %h want 00002000", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h00BE_EF00) begin n_fail++; $display("FAIL sh_wdata got %h want 00beef00", mem_wdata); end
    n_cmp++; if (mem_be !== 4'b0110) begin n_fail++; $display("FAIL sh_be got %b want 0110", mem_be); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL sh_done_valid got %b want 0", mem_valid); end
    // word at offset 0 and half at offset 2 are single beats
    issue(3'b000, 32'h0000_2100, 32'h1234_5678);
    n_cmp++; if (mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL sw0_wdata got %h want 12345678", mem_wdata); end
    n_cmp++; if (mem_be !== 4'b1111) begin n_fail++; $display("FAIL sw0_be got %b want 1111", mem_be); end
    @(negedge clk);
    issue(3'b010, 32'h0000_2202, 32'hAAAA_1357);
    n_cmp++; if (mem_wdata !== 32'h1357_0000) begin n_fail++; $display("FAIL sh2_wdata got %h want 13570000", mem_wdata); end
    n_cmp++; if (mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh2_be got %b want 1100", mem_be); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL sh2_done_valid got %b want 0", mem_valid); end
  endtask

  task automatic test_cross(input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] b0,
                            input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] b1);
    mem_ready = 1'b1;
    issue(3'b000, a, d);
`ifdef STORE_ALIGN_SPLIT_EN
    n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL cross_b0_valid got %b want 1", mem_valid); end
    n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL cross_b0_err got %b want 0", st_err); end
    n_cmp++; if (mem_addr !== a0) begin n_fail++; $display("FAIL cross_b0_addr got %h want %h", mem_addr, a0); end
    n_cmp++; if (mem_wdata !== w0) begin n_fail++; $display("FAIL cross_b0_wdata got %h want %h", mem_wdata, w0); end
    n_cmp++; if (mem_be !== b0) begin n_fail++; $display("FAIL cross_b0_be got %b want %b", mem_be, b0); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL cross_b1_valid got %b want 1", mem_valid); end
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL cross_b1_ready got %b want 0", st_ready); end
    n_cmp++; if (mem_addr !== a1) begin n_fail++; $display("FAIL cross_b1_addr got %h want %h", mem_addr, a1); end
    n_cmp++; if (mem_wdata !== w1) begin n_fail++; $display("FAIL cross_b1_wdata got %h want %h", mem_wdata, w1); end
    n_cmp++; if (mem_be !== b1) begin n_fail++; $display("FAIL cross_b1_be got %b want %b", mem_be, b1); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL cross_done_valid got %b want 0", mem_valid); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL cross_done_ready got %b want 1", st_ready); end
`else
    n_cmp++; if (st_err !== 1'b1) begin n_fail++; $display("FAIL cross_rej_err got %b want 1 (a0 %h w0 %h b0 %b)", st_err, a0, w0, b0); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL cross_rej_valid got %b want 0 (a1 %h w1 %h b1 %b)", mem_valid, a1, w1, b1); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL cross_rej_ready got %b want 1", st_ready); end
    @(negedge clk);
    n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL cross_rej_err_pulse got %b want 0", st_err); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL cross_rej_valid2 got %b want 0", mem_valid); end
`endif
  endtask

  task automatic test_stall_illegal();
    mem_ready = 1'b0;
    issue(3'b000, 32'h0000_4000, 32'hDEAD_BEEF);
    // a competing request while busy must be ignored
    st_valid = 1'b1; st_size = 3'b001; st_addr = 32'h0000_4101; st_data = 32'h0000_0011;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", i, mem_valid); end
      n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, st_ready); end
      n_cmp++; if (mem_addr !== 32'h0000_4000) begin n_fail++; $display("FAIL stall_addr[%0d] got %h want 00004000", i, mem_addr); end
      n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_wdata[%0d] got %h want deadbeef", i, mem_wdata); end
      n_cmp++; if (mem_be !== 4'b1111) begin n_fail++; $display("FAIL stall_be[%0d] got %b want 1111", i, mem_be); end
      @(negedge clk);
    end
    st_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid got %b want 0", mem_valid); end
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_extra_beat got %b want 0", mem_valid); end
    // illegal sizes
    issue(3'b011, 32'h0000_4200, 32'h0000_0001);
    n_cmp++; if (st_err !== 1'b1) begin n_fail++; $display("FAIL ill3_err got %b want 1", st_err); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL ill3_valid got %b want 0", mem_valid); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL ill3_ready got %b want 1", st_ready); end
    @(negedge clk);
    n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL ill3_pulse got %b want 0", st_err); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL ill3_valid2 got %b want 0", mem_valid); end
    issue(3'b111, 32'h0000_4300, 32'h0000_0002);
    n_cmp++; if (st_err !== 1'b1) begin n_fail++; $display("FAIL ill7_err got %b want 1", st_err); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL ill7_valid got %b want 0", mem_valid); end
    @(negedge clk);
    n_cmp++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL ill7_pulse got %b want 0", st_err); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    st_size = 3'b001; st_addr = 32'h0000_6002; st_data = 32'h0000_0077; st_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (mem_valid !== ((i % 2) == 0)) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want %b", i, mem_valid, (i % 2) == 0); end
      n_cmp++; if (st_ready !== ((i % 2) == 1)) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want %b", i, st_ready, (i % 2) == 1); end
      if ((i % 2) == 0) begin
        n_cmp++; if (mem_wdata !== 32'h0077_0000 || mem_be !== 4'b0100) begin n_fail++; $display("FAIL b2b_data[%0d] got %h/%b want 00770000/0100", i, mem_wdata, mem_be); end
      end
      if (i == 5) st_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b want 0", mem_valid); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1;
`ifdef STORE_ALIGN_SPLIT_EN
    issue(3'b000, 32'h0000_5002, 32'h5566_7788);
    mem_ready = 1'b0;
    @(negedge clk);
`else
    mem_ready = 1'b0;
    issue(3'b000, 32'h0000_5000, 32'h5566_7788);
    @(negedge clk);
`endif
    n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending_valid got %b want 1", mem_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got %b want 0", mem_valid); end
    n_cmp++; if (mem_be !== 4'b0) begin n_fail++; $display("FAIL mid_async_be got %b want 0000", mem_be); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid[%0d] got %b want 0", i, mem_valid); end
      n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready[%0d] got %b want 1", i, st_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_cross(32'h0000_3002, 32'h1122_3344,
               32'h0000_3000, 32'h3344_0000, 4'b1100,
               32'h0000_3004, 32'h0000_1122, 4'b0011);
    test_cross(32'hFFFF_FFFE, 32'hAABB_CCDD,
               32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100,
               32'h0000_0000, 32'h0000_AABB, 4'b0011);
    test_stall_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
